// File: rtl/alu128_rr_scheduler.sv
// Round-robin scheduler sharing one external 128-bit ALU between NREQ requesters.
// Optional macro ALU_SCHED_OPCHK_EN: opcodes >= 4'hA are answered at once with rsp_err=1.
module alu128_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_op,
    input  logic [128*NREQ-1:0]   req_a,
    input  logic [128*NREQ-1:0]   req_b,
    output logic [127:0]          alu_ip1,
    output logic [127:0]          alu_ip2,
    output logic [3:0]            alu_sel,
    input  logic [127:0]          alu_result,
    input  logic [4:0]            alu_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [127:0]          rsp_result,
    output logic [4:0]            rsp_flags,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [CNTW-1:0]       op_count
);

    // Handshakes: a request or response transfers on a rising edge where its valid and
    // ready are both high; the sender holds valid and payload stable until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDW-1:0] RR_INIT = IDW'(NREQ - 1);

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           grant_vld;
    logic           grant_bad;
    logic           accept;
    logic [3:0]     grant_op;
    logic [127:0]   grant_a;
    logic [127:0]   grant_b;

    // Scan from the far end so the candidate closest after rr_ptr is written last and wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_op = '0;
        grant_a  = '0;
        grant_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_op = req_op[4*i +: 4];
                grant_a  = req_a[128*i +: 128];
                grant_b  = req_b[128*i +: 128];
            end
        end
    end

`ifdef ALU_SCHED_OPCHK_EN
    assign grant_bad = (grant_op >= 4'hA);
`else
    assign grant_bad = 1'b0;
`endif

    assign accept = (state == IDLE) && grant_vld;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = grant_bad ? RESP : EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drive registers only move on a legal accept, so the ALU inputs stay quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= RR_INIT;
            alu_ip1    <= '0;
            alu_ip2    <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= grant_idx;
                rsp_id <= grant_idx;
                if (grant_bad) begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= '0;
                    rsp_flags  <= '0;
                end else begin
                    alu_ip1 <= grant_a;
                    alu_ip2 <= grant_b;
                    alu_sel <= grant_op;
                end
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                if (op_count != {CNTW{1'b1}}) begin
                    op_count <= op_count + 1'b1;
                end
            end
        end
    end

`ifdef ALU_SCHED_OPCHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept && grant_bad) begin
            rsp_err <= 1'b1;
        end else if (state == EXEC) begin
            rsp_err <= 1'b0;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
